// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte producers (round-robin by default).
// Define UART_ARB_FIXED_PRIO_EN for strict lowest-index-first priority.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_LENGTH = 8,
    parameter int GAP_TICKS   = 2
) (
    input  logic                         clk1,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*DATA_LENGTH-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [DATA_LENGTH-1:0]       tx_datain,
    output logic                         tx_send,
    input  logic                         tx_done,
    input  logic                         baud_tick,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         busy
);
    localparam int IW  = $clog2(N_REQ);
    localparam int IW1 = IW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY,
        GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [N_REQ-1:0]       ready_q, ready_d;
    logic [DATA_LENGTH-1:0] data_q, data_d;
    logic [IW-1:0]          gid_q, gid_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [IW-1:0]          start;
    logic                   found;
    logic [IW-1:0]          winner;

`ifdef UART_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    assign start = rr_ptr_q;
`endif

    // First set request bit searching upward from start, wrapping at N_REQ.
    always_comb begin
        logic [IW:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, start} + IW1'(i);
            if (idx >= IW1'(N_REQ)) begin
                idx = idx - IW1'(N_REQ);
            end
            if (!found && req_valid[idx[IW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = '0;
        data_d  = data_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
`ifndef UART_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d         = LAUNCH;
                    ready_d[winner] = 1'b1;
                    data_d          = req_data[winner*DATA_LENGTH +: DATA_LENGTH];
                    gid_d           = winner;
`ifndef UART_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
`endif
                end
            end
            LAUNCH: begin
                if (!tx_done) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A tick coinciding with tx_done is dropped: the counter restarts here.
                if (tx_done) begin
                    cnt_d   = '0;
                    state_d = (GAP_TICKS == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (baud_tick && (cnt_q < 4'(GAP_TICKS))) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == 4'(GAP_TICKS)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst) begin
            state_q  <= IDLE;
            ready_q  <= '0;
            data_q   <= '0;
            gid_q    <= '0;
            cnt_q    <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
            cnt_q    <= cnt_d;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign tx_datain = data_q;
    assign grant_id  = gid_q;
    assign tx_send   = (state_q == LAUNCH);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, hand sequences and a randomized run
// checked cycle by cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int GAP   = 2;
    localparam int BAUD  = 4;
    localparam int FRAME = 3;
`ifdef UART_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [DW-1:0] tx_datain;
    logic          tx_send;
    logic          tx_done;
    logic          baud_tick;
    logic [1:0]    grant_id;
    logic          busy;

    logic [N-1:0]  b_valid;
    logic [N*DW-1:0] b_data;
    logic [N-1:0]  b_ready;
    logic [DW-1:0] b_datain;
    logic          b_send;
    logic          b_done;
    logic          b_tick;
    logic [1:0]    b_gid;
    logic          b_busy;

    uart_tx_arbiter #(.N_REQ(N), .DATA_LENGTH(DW), .GAP_TICKS(GAP)) u_dut (
        .clk1(clk1), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_datain(tx_datain), .tx_send(tx_send), .tx_done(tx_done),
        .baud_tick(baud_tick), .grant_id(grant_id), .busy(busy)
    );

    uart_tx_arbiter #(.N_REQ(N), .DATA_LENGTH(DW), .GAP_TICKS(0)) u_dut_g0 (
        .clk1(clk1), .rst(rst),
        .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
        .tx_datain(b_datain), .tx_send(b_send), .tx_done(b_done),
        .baud_tick(b_tick), .grant_id(b_gid), .busy(b_busy)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one arbitration round = grant, wait frame start,
    // wait frame end, then count GAP ticks.
    int m_stage = 0;
    int m_ptr = 0;
    int m_ticks = 0;
    logic [N-1:0]  e_rdy;
    logic          e_send, e_busy;
    logic [1:0]    e_gid;
    logic [DW-1:0] e_dat;

    task automatic model_edge();
        int w;
        int s;
        e_rdy = '0;
        if (!rst) begin
            m_stage = 0; m_ptr = 0; m_ticks = 0;
            e_gid = '0; e_dat = '0;
        end else begin
            case (m_stage)
                0: if (req_valid != 0) begin
                    s = FIXED ? 0 : m_ptr;
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && req_valid[(s + k) % N]) w = (s + k) % N;
                    e_rdy[w] = 1'b1;
                    e_gid = 2'(w);
                    e_dat = req_data[w*DW +: DW];
                    m_ptr = (w + 1) % N;
                    m_stage = 1;
                end
                1: if (!tx_done) m_stage = 2;
                2: if (tx_done) begin
                    m_ticks = 0;
                    m_stage = (GAP == 0) ? 0 : 3;
                end
                default: if (baud_tick) begin
                    m_ticks++;
                    if (m_ticks >= GAP) m_stage = 0;
                end
            endcase
        end
        e_send = (m_stage == 1);
        e_busy = (m_stage != 0);
    endtask

    // Behavioural transmitter used when auto_tx is set.
    bit auto_tx = 1'b0;
    bit tx_act = 1'b0;
    int tx_left = 0;
    int baud_cnt = 0;

    task automatic tx_advance();
        if (baud_tick) begin
            if (tx_act) begin
                tx_left--;
                if (tx_left == 0) begin tx_act = 1'b0; tx_done = 1'b1; end
            end else if (tx_send) begin
                tx_act = 1'b1; tx_left = FRAME; tx_done = 1'b0;
            end
        end
        baud_cnt = (baud_cnt + 1) % BAUD;
        baud_tick = (baud_cnt == 0);
    endtask

    task automatic step();
        @(negedge clk1);
        model_edge();
        chk("req_ready", int'(req_ready), int'(e_rdy));
        chk("tx_send", int'(tx_send), int'(e_send));
        chk("busy", int'(busy), int'(e_busy));
        chk("grant_id", int'(grant_id), int'(e_gid));
        chk("tx_datain", int'(tx_datain), int'(e_dat));
        if (auto_tx) tx_advance();
    endtask

    task automatic wait_grant(output int gid);
        gid = -1;
        for (int c = 0; c < 400; c++) begin
            step();
            if (req_ready != 0) begin
                gid = int'(grant_id);
                break;
            end
        end
        if (gid < 0) begin
            n_total++;
            $display("FAIL grant_timeout: got none expected a grant at %0t", $time);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL idle_timeout: got busy expected idle at %0t", $time);
        end
    endtask

    typedef struct {
        logic          rst;
        logic [N-1:0]  v;
        logic          done;
        logic          tick;
        logic [N-1:0]  rdy;
        logic          send;
        logic          bsy;
        logic [1:0]    gid;
        logic [DW-1:0] dat;
    } vec_t;

    function automatic vec_t mk(logic r, logic [3:0] v, logic d, logic t,
                                logic [3:0] rd, logic s, logic b,
                                logic [1:0] g, logic [7:0] da);
        vec_t x;
        x.rst = r; x.v = v; x.done = d; x.tick = t;
        x.rdy = rd; x.send = s; x.bsy = b; x.gid = g; x.dat = da;
        return x;
    endfunction

    vec_t tbl[15];
    logic [N-1:0] pend;

    initial begin
        int g;
        tbl[0]  = mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 8'h00);
        tbl[1]  = mk(1, 4'b0100, 1, 0, 4'b0100, 1, 1, 2, 8'hA5);
        tbl[2]  = mk(1, 4'b0000, 1, 0, 4'b0000, 1, 1, 2, 8'hA5);
        tbl[3]  = mk(1, 4'b0000, 0, 0, 4'b0000, 0, 1, 2, 8'hA5);
        tbl[4]  = mk(1, 4'b0000, 0, 1, 4'b0000, 0, 1, 2, 8'hA5);
        tbl[5]  = mk(1, 4'b0001, 1, 1, 4'b0000, 0, 1, 2, 8'hA5);
        tbl[6]  = mk(1, 4'b0001, 1, 1, 4'b0000, 0, 1, 2, 8'hA5);
        tbl[7]  = mk(1, 4'b0001, 1, 0, 4'b0000, 0, 1, 2, 8'hA5);
        tbl[8]  = mk(1, 4'b0001, 1, 1, 4'b0000, 0, 0, 2, 8'hA5);
        tbl[9]  = mk(1, 4'b0001, 1, 0, 4'b0001, 1, 1, 0, 8'h11);
        tbl[10] = mk(1, 4'b0000, 1, 0, 4'b0000, 1, 1, 0, 8'h11);
        tbl[11] = mk(1, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 8'h11);
        tbl[12] = mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 8'h00);
        tbl[13] = mk(1, 4'b1111, 1, 0, 4'b0001, 1, 1, 0, 8'h11);
        tbl[14] = mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 8'h00);

        req_data = 32'h33A5_2211;
        b_valid = '0; b_data = '0; b_done = 1'b1; b_tick = 1'b0;
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst;
            req_valid = tbl[i].v;
            tx_done = tbl[i].done;
            baud_tick = tbl[i].tick;
            step();
            chk($sformatf("row%0d_rdy", i), int'(req_ready), int'(tbl[i].rdy));
            chk($sformatf("row%0d_send", i), int'(tx_send), int'(tbl[i].send));
            chk($sformatf("row%0d_busy", i), int'(busy), int'(tbl[i].bsy));
            chk($sformatf("row%0d_gid", i), int'(grant_id), int'(tbl[i].gid));
            chk($sformatf("row%0d_dat", i), int'(tx_datain), int'(tbl[i].dat));
        end

        // GAP_TICKS=0 instance: requester 1 stays valid across frames.
        rst = 1'b1; req_valid = '0; tx_done = 1'b1; baud_tick = 1'b0;
        b_valid = 4'b0010; b_data = 32'h0000_5A00;
        step();
        chk("g0_rdy1", int'(b_ready), 2);
        chk("g0_send1", int'(b_send), 1);
        chk("g0_gid", int'(b_gid), 1);
        chk("g0_dat", int'(b_datain), 8'h5A);
        b_done = 1'b0;
        step();
        chk("g0_busy_frame", int'(b_busy), 1);
        chk("g0_send_low", int'(b_send), 0);
        b_done = 1'b1; b_tick = 1'b1;
        step();
        chk("g0_busy_fall", int'(b_busy), 0);
        chk("g0_rdy_none", int'(b_ready), 0);
        b_tick = 1'b0;
        step();
        chk("g0_rdy2", int'(b_ready), 2);
        chk("g0_busy2", int'(b_busy), 1);
        b_valid = '0;

        // Fairness wrap with the behavioural transmitter.
        auto_tx = 1'b1; tx_act = 1'b0; tx_done = 1'b1; baud_cnt = 0;
        req_data = 32'h3C2B_1A09;
        req_valid = 4'b1000;
        wait_grant(g);
        chk("fair_g3", g, 3);
        req_valid = '0;
        wait_idle();
        req_valid = 4'b1001;
        wait_grant(g);
        chk("fair_first", g, 0);
        req_valid = 4'b1000;
        wait_grant(g);
        chk("fair_second", g, 3);
        req_valid = '0;
        wait_idle();

        // All four held valid.
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            chk($sformatf("all4_g%0d", k), g, FIXED ? 0 : k % 4);
        end
        // Two held valid.
        req_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            wait_grant(g);
            chk($sformatf("pair_g%0d", k), g, FIXED ? 0 : ((k % 2 == 0) ? 1 : 0));
        end
        req_valid = '0;
        wait_idle();

        // Randomized producers, withdrawals and occasional resets.
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) pend[i] = 1'b0;
                else if (pend[i] && $urandom_range(63) == 0) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(7) == 0) begin
                    pend[i] = 1'b1;
                    req_data[i*DW +: DW] = 8'($urandom);
                end
            end
            req_valid = pend;
            rst = ($urandom_range(599) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
